// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: multi-digit seven-segment controller with hex or double-dabble decimal display,
// leading-zero blanking, per-digit blink and overflow dashes.
module seg_display_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DATA_W-1:0]   data,
  input  logic                mode,
  input  logic                blank_lz,
  input  logic                blink_en,
  input  logic [DIGITS-1:0]   blink_mask,
  output logic [7*DIGITS-1:0] hex_segs,
  output logic                busy,
  output logic                done,
  output logic                ovf
);
  localparam int DW = 4*DIGITS;
  localparam int AW = DW + 4;
  localparam int EW = DATA_W > DW ? DATA_W : DW;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [63:0] MAX_DEC = 64'(10**DIGITS - 1);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic {IDLE, CONV} state_t;
  state_t state;
  logic [DW-1:0] digs;
  logic [AW-1:0] acc, adj, acc_next;
  logic [DATA_W-1:0] sr;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic phase;
  logic [EW-1:0] ext;
  logic [DIGITS-1:0] lz;
  assign ext = EW'(data);
  assign acc_next = (adj << 1) | AW'(sr[DATA_W-1]);
  for (genvar i = 0; i <= DIGITS; i++) begin : g_adj
    assign adj[4*i+:4] = acc[4*i+:4] >= 4'd5 ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
  end
  // Priority: overflow dash, then blink blank, then leading-zero blank, then glyph
  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    assign lz[i] = blank_lz && i != 0 && digs[DW-1:4*i] == '0;
    assign hex_segs[7*i+:7] = ovf ? DASH :
                              (blink_en && phase && blink_mask[i]) || lz[i] ? BLANK :
                              GLYPH[digs[4*i+:4]];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      digs <= '0;
      acc <= '0;
      sr <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load) begin
          ovf <= mode ? 64'(data) > MAX_DEC : |(ext >> DW);
          if (mode) begin
            sr <= data;
            acc <= '0;
            cnt <= CW'(DATA_W);
            busy <= 1'b1;
            state <= CONV;
          end else begin
            digs <= ext[DW-1:0];
            done <= 1'b1;
          end
        end
        CONV: begin
          acc <= acc_next;
          sr <= sr << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            digs <= acc_next[DW-1:0];
            busy <= 1'b0;
            done <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bcnt <= '0;
      phase <= 1'b0;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt <= '0;
      phase <= ~phase;
    end else
      bcnt <= bcnt + BW'(1);
endmodule
